mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle successor to the single-cycle control decoder. A Moore/Mealy FSM sequences each MIPS instruction through fetch, decode, execute, memory and write-back on one shared memory port. It waits on a memory ready handshake with a parametrised timeout, and traps on illegal opcodes or bus timeouts. It sits between the instruction register/ALU datapath and the unified instruction/data memory.

## Interface
- TIMEOUT, 15: max cycles waiting on mem_ready before bus error; 0 disables timeout
- CNT_W, 4: wait-counter width; TIMEOUT < 2^CNT_W required
- TRAP_EN, 1: 1 = illegal opcode traps; 0 = illegal opcode retires as NOP
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  6  IR[31:26], stable from ID until next IF
- ins  in  6  IR[5:0] funct
- alu_zero  in  1  ALU zero flag, valid in EX
- mem_ready  in  1  memory completes current access this cycle
- trap_ack  in  1  clears TRAP
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  memory enable/read/write, active-low
- iord  out  1  0 = address from PC, 1 = address from ALU result
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  3  000 PC+4, 001 branch target, 010 jump target, 011 rs (jr), 100 trap vector
- regdst, alu_src, mem_to_reg, reg_write, jal  out  1 each  datapath selects/enables
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 reserved
- trap  out  1  high while in TRAP
- trap_cause  out  2  registered: 00 none, 01 illegal opcode, 10 bus timeout
- retire  out  1  one-cycle pulse per completed instruction
- state  out  3  current state, for debug

## Operation
- States: RST=0, IF=1, ID=2, EX=3, MEM=4, WB=5, TRAP=6. Values 7 go to RST.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, ADDI 001000, BEQ 000100, BNE 000101, J 000010, JAL 000011. JR = RTYPE with funct 001000. Anything else is illegal.
- All outputs are 0 except mem_* = 1, unless listed for the state below.
- RST: no outputs; always goes to IF.
- IF: mem_ce_n=0, mem_oe_n=0, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=000, go to ID.
  - Otherwise stay in IF.
- ID:
  - J: pc_write=1, pc_src=010, retire, go to IF.
  - JAL: same as J plus reg_write=1, jal=1.
  - JR: pc_write=1, pc_src=011, retire, go to IF.
  - Illegal with TRAP_EN=1: trap_cause<=01, go to TRAP.
  - Illegal with TRAP_EN=0: retire, go to IF.
  - Otherwise go to EX.
- EX:
  - RTYPE: alu_op=10, go to WB.
  - ADDI/LW/SW: alu_op=00, alu_src=1; ADDI goes to WB, LW/SW go to MEM.
  - BEQ/BNE: alu_op=01. pc_write = alu_zero for BEQ, !alu_zero for BNE; pc_src=001. Retire, go to IF.
- MEM: mem_ce_n=0, iord=1, alu_op=00, alu_src=1. LW drives mem_oe_n=0; SW drives mem_we_n=0.
  - On mem_ready: LW goes to WB; SW retires and goes to IF.
- WB: reg_write=1, regdst=(RTYPE), mem_to_reg=(LW), retire, go to IF.
- TRAP: trap=1, no memory access. On trap_ack: pc_write=1, pc_src=100, trap_cause<=00, go to IF.
- Wait counter:
  - Cleared on entry to IF/MEM and on mem_ready; increments each waiting cycle; saturates at 2^CNT_W−1.
  - In IF or MEM with TIMEOUT≠0, count==TIMEOUT and !mem_ready: trap_cause<=10, go to TRAP, no strobes that cycle.

## Timing
- Reset (async, rst_n low): state=RST, count=0, trap_cause=00. All outputs are idle: mem_* = 1, everything else 0, state=0. The first rising edge after release goes to IF.
- Cycles per instruction with zero-wait memory (mem_ready=1 on the first cycle):
  - J/JAL/JR: 2.
  - BEQ/BNE: 3.
  - RTYPE/ADDI: 4.
  - SW: 4.
  - LW: 5.
- Each wait cycle in IF/MEM adds 1.
- Outputs are combinational from state, opcode/funct, alu_zero and mem_ready. Only state, count and trap_cause are registered.
- mem_ready outside IF/MEM is ignored.
- trap_ack outside TRAP is ignored.
- trap_ack in the same cycle as trap entry has no effect.
- Reset asserted mid-access drops all strobes immediately (asynchronous).

## Test plan
- Reset, mem_ready tied 1, stream ADDI, LW, SW, BEQ (alu_zero=1), J → states 1-2-3-5, 1-2-3-4-5, 1-2-3-4, 1-2-3, 1-2. retire counts 5 in 18 cycles after RST.
- BNE with alu_zero=1 → pc_write=0 in EX. Same with alu_zero=0 → pc_write=1 with pc_src=001.
- RTYPE funct 001000 (JR) → pc_src=011 in ID, no reg_write. JAL → reg_write=1, jal=1, pc_src=010 in ID.
- LW with mem_ready held low in MEM, TIMEOUT=15 → 15 wait cycles with mem_oe_n=0, then TRAP with trap_cause=10. trap_ack → pc_src=100, back to IF, trap_cause=00.
- Opcode 111111 with TRAP_EN=1 → TRAP, trap_cause=01. With TRAP_EN=0 → retire in ID, next state IF.
- rst_n pulled low during MEM of SW → mem_we_n=1 and state=0 within the same cycle. After release, one RST cycle, then IF.

Source files
------------

// File: rtl/mc_control_if.sv
// mc_control_if
// Bus between the multi-cycle controller and the unified instruction/data
// memory.
//
// Signals:
//   mem_ce_n   chip enable, active-low (controller -> memory)
//   mem_oe_n   read enable, active-low (controller -> memory)
//   mem_we_n   write enable, active-low (controller -> memory)
//   iord       address select: 0 = PC, 1 = ALU result (controller -> datapath mux)
//   mem_ready  memory completes the current access this cycle (memory -> controller)
//
// The master modport is the controller side. The slave modport is the memory side.
interface mc_control_if;
    logic mem_ce_n;
    logic mem_oe_n;
    logic mem_we_n;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_ce_n,
        output mem_oe_n,
        output mem_we_n,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_ce_n,
        input  mem_oe_n,
        input  mem_we_n,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/mc_control.sv
// mc_control
// Multi-cycle MIPS control FSM. Each instruction is sequenced through fetch,
// decode, execute, memory and write-back. A single memory port is shared for
// instruction and data accesses. Waits on the memory are bounded by a
// timeout. Illegal opcodes and bus timeouts enter a TRAP state, which is left
// on trap_ack.
//
// Parameters:
//   TIMEOUT  maximum cycles spent waiting on mem_ready before a bus error
//            (0 disables the timeout); must be below 2**CNT_W
//   CNT_W    wait-counter width
//   TRAP_EN  1 = illegal opcodes trap, 0 = illegal opcodes retire as NOP
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus               memory strobes, address select and mem_ready (master side)
//   i_opcode, i_ins   IR[31:26] and IR[5:0]
//   i_alu_zero        ALU zero flag, sampled in EX
//   i_trap_ack        leaves TRAP
//   o_ir_write        load the instruction register
//   o_pc_write        load the program counter
//   o_pc_src          PC source select
//   o_regdst, o_alu_src, o_mem_to_reg, o_reg_write, o_jal   datapath controls
//   o_alu_op          00 add, 01 sub, 10 funct
//   o_trap            high while in TRAP
//   o_trap_cause      registered cause: 00 none, 01 illegal opcode, 10 bus timeout
//   o_retire          one-cycle pulse per completed instruction
//   o_state           current state (debug)
module mc_control #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4,
    parameter bit          TRAP_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_control_if.master bus,
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_ins,
    input  logic         i_alu_zero,
    input  logic         i_trap_ack,
    output logic         o_ir_write,
    output logic         o_pc_write,
    output logic [2:0]   o_pc_src,
    output logic         o_regdst,
    output logic         o_alu_src,
    output logic         o_mem_to_reg,
    output logic         o_reg_write,
    output logic         o_jal,
    output logic [1:0]   o_alu_op,
    output logic         o_trap,
    output logic [1:0]   o_trap_cause,
    output logic         o_retire,
    output logic [2:0]   o_state
);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_TRAP = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] PC_PLUS4  = 3'b000;
    localparam logic [2:0] PC_BRANCH = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_RS     = 3'b011;
    localparam logic [2:0] PC_TRAP   = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam bit               TIMEOUT_ON  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_trap_cause;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_count_inc;
    logic [1:0]       w_trap_cause_next;
    logic             w_timeout;

    logic w_is_rtype;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_addi;
    logic w_is_beq;
    logic w_is_bne;
    logic w_is_j;
    logic w_is_jal;
    logic w_is_jr;
    logic w_legal;

    // Opcode decode; JR is an R-type encoding that is resolved in ID.
    assign w_is_rtype = (i_opcode == OP_RTYPE);
    assign w_is_lw    = (i_opcode == OP_LW);
    assign w_is_sw    = (i_opcode == OP_SW);
    assign w_is_addi  = (i_opcode == OP_ADDI);
    assign w_is_beq   = (i_opcode == OP_BEQ);
    assign w_is_bne   = (i_opcode == OP_BNE);
    assign w_is_j     = (i_opcode == OP_J);
    assign w_is_jal   = (i_opcode == OP_JAL);
    assign w_is_jr    = w_is_rtype && (i_ins == FN_JR);
    assign w_legal    = w_is_rtype | w_is_lw | w_is_sw | w_is_addi |
                        w_is_beq | w_is_bne | w_is_j | w_is_jal;

    // The counter saturates so that a disabled timeout cannot wrap into a
    // false match later.
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);

    // The bus error fires only while a memory access is outstanding.
    assign w_timeout = TIMEOUT_ON && (r_count == TIMEOUT_CNT) && !bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RST;
            r_count      <= '0;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            r_state      <= w_next_state;
            r_count      <= w_count_next;
            r_trap_cause <= w_trap_cause_next;
        end
    end

    // Next state and all control outputs. The counter defaults to zero, so it
    // is cleared on every entry into IF/MEM and on every mem_ready. It only
    // advances while a wait state is held.
    always_comb begin
        w_next_state      = ST_RST;
        w_count_next      = '0;
        w_trap_cause_next = r_trap_cause;
        bus.mem_ce_n      = 1'b1;
        bus.mem_oe_n      = 1'b1;
        bus.mem_we_n      = 1'b1;
        bus.iord          = 1'b0;
        o_ir_write        = 1'b0;
        o_pc_write        = 1'b0;
        o_pc_src          = PC_PLUS4;
        o_regdst          = 1'b0;
        o_alu_src         = 1'b0;
        o_mem_to_reg      = 1'b0;
        o_reg_write       = 1'b0;
        o_jal             = 1'b0;
        o_alu_op          = ALU_ADD;
        o_trap            = 1'b0;
        o_retire          = 1'b0;

        case (r_state)
            ST_RST: begin
                w_next_state = ST_IF;
            end

            ST_IF: begin
                if (w_timeout) begin
                    w_trap_cause_next = CAUSE_TIMEOUT;
                    w_next_state      = ST_TRAP;
                end else begin
                    bus.mem_ce_n = 1'b0;
                    bus.mem_oe_n = 1'b0;
                    if (bus.mem_ready) begin
                        o_ir_write   = 1'b1;
                        o_pc_write   = 1'b1;
                        o_pc_src     = PC_PLUS4;
                        w_next_state = ST_ID;
                    end else begin
                        w_count_next = w_count_inc;
                        w_next_state = ST_IF;
                    end
                end
            end

            ST_ID: begin
                if (w_is_j || w_is_jal) begin
                    o_pc_write   = 1'b1;
                    o_pc_src     = PC_JUMP;
                    o_reg_write  = w_is_jal;
                    o_jal        = w_is_jal;
                    o_retire     = 1'b1;
                    w_next_state = ST_IF;
                end else if (w_is_jr) begin
                    o_pc_write   = 1'b1;
                    o_pc_src     = PC_RS;
                    o_retire     = 1'b1;
                    w_next_state = ST_IF;
                end else if (!w_legal) begin
                    if (TRAP_EN) begin
                        w_trap_cause_next = CAUSE_ILLEGAL;
                        w_next_state      = ST_TRAP;
                    end else begin
                        o_retire     = 1'b1;
                        w_next_state = ST_IF;
                    end
                end else begin
                    w_next_state = ST_EX;
                end
            end

            ST_EX: begin
                if (w_is_rtype) begin
                    o_alu_op     = ALU_FUNCT;
                    w_next_state = ST_WB;
                end else if (w_is_addi) begin
                    o_alu_op     = ALU_ADD;
                    o_alu_src    = 1'b1;
                    w_next_state = ST_WB;
                end else if (w_is_lw || w_is_sw) begin
                    o_alu_op     = ALU_ADD;
                    o_alu_src    = 1'b1;
                    w_next_state = ST_MEM;
                end else begin
                    // Only BEQ/BNE remain, because jumps and illegal opcodes
                    // never leave ID towards EX.
                    o_alu_op     = ALU_SUB;
                    o_pc_write   = w_is_beq ? i_alu_zero : !i_alu_zero;
                    o_pc_src     = PC_BRANCH;
                    o_retire     = 1'b1;
                    w_next_state = ST_IF;
                end
            end

            ST_MEM: begin
                bus.iord  = 1'b1;
                o_alu_op  = ALU_ADD;
                o_alu_src = 1'b1;
                if (w_timeout) begin
                    w_trap_cause_next = CAUSE_TIMEOUT;
                    w_next_state      = ST_TRAP;
                end else begin
                    bus.mem_ce_n = 1'b0;
                    bus.mem_oe_n = !w_is_lw;
                    bus.mem_we_n = !w_is_sw;
                    if (bus.mem_ready) begin
                        if (w_is_lw) begin
                            w_next_state = ST_WB;
                        end else begin
                            o_retire     = 1'b1;
                            w_next_state = ST_IF;
                        end
                    end else begin
                        w_count_next = w_count_inc;
                        w_next_state = ST_MEM;
                    end
                end
            end

            ST_WB: begin
                o_reg_write  = 1'b1;
                o_regdst     = w_is_rtype;
                o_mem_to_reg = w_is_lw;
                o_retire     = 1'b1;
                w_next_state = ST_IF;
            end

            ST_TRAP: begin
                o_trap = 1'b1;
                if (i_trap_ack) begin
                    o_pc_write        = 1'b1;
                    o_pc_src          = PC_TRAP;
                    w_trap_cause_next = CAUSE_NONE;
                    w_next_state      = ST_IF;
                end else begin
                    w_next_state = ST_TRAP;
                end
            end

            default: begin
                w_next_state = ST_RST;
            end
        endcase
    end

    assign o_trap_cause = r_trap_cause;
    assign o_state      = r_state;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
// Directed testbench for mc_control. DUT A uses TRAP_EN=1 and DUT B uses
// TRAP_EN=0. Both use TIMEOUT=15. Each applyStimulus call drives one cycle of
// inputs and queues the hand-computed output vector for that cycle. A
// negedge monitor pops the queue and compares it with the selected DUT.
// Vector layout:
//   {ce_n, oe_n, we_n, iord, ir_write, pc_write, pc_src[3], regdst, alu_src,
//    mem_to_reg, reg_write, jal, alu_op[2], trap, trap_cause[2], retire, state[3]}
module tb_mc_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BAD   = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    typedef struct {
        int          sel;
        logic [22:0] v;
        string       name;
    } exp_t;

    logic clk;
    logic rstA, rstB, nextRstA, nextRstB;
    logic [5:0] opcode, ins;
    logic aluZero, ready, trapAck;

    logic irwA, pcwA, regdstA, aluSrcA, memToRegA, regWriteA, jalA, trapA, retireA;
    logic irwB, pcwB, regdstB, aluSrcB, memToRegB, regWriteB, jalB, trapB, retireB;
    logic [2:0] pcSrcA, pcSrcB, stateA, stateB;
    logic [1:0] aluOpA, aluOpB, causeA, causeB;

    logic [22:0] outA, outB;

    exp_t expQ[$];
    int   asserts;
    int   failures;
    int   retireCnt;
    bit   countRetire;

    mc_control_if busA ();
    mc_control_if busB ();

    assign busA.mem_ready = ready;
    assign busB.mem_ready = ready;

    mc_control #(.TIMEOUT(15), .CNT_W(4), .TRAP_EN(1'b1)) dutA (
        .clk(clk), .rst_n(rstA), .bus(busA),
        .i_opcode(opcode), .i_ins(ins), .i_alu_zero(aluZero), .i_trap_ack(trapAck),
        .o_ir_write(irwA), .o_pc_write(pcwA), .o_pc_src(pcSrcA), .o_regdst(regdstA),
        .o_alu_src(aluSrcA), .o_mem_to_reg(memToRegA), .o_reg_write(regWriteA),
        .o_jal(jalA), .o_alu_op(aluOpA), .o_trap(trapA), .o_trap_cause(causeA),
        .o_retire(retireA), .o_state(stateA)
    );

    mc_control #(.TIMEOUT(15), .CNT_W(4), .TRAP_EN(1'b0)) dutB (
        .clk(clk), .rst_n(rstB), .bus(busB),
        .i_opcode(opcode), .i_ins(ins), .i_alu_zero(aluZero), .i_trap_ack(trapAck),
        .o_ir_write(irwB), .o_pc_write(pcwB), .o_pc_src(pcSrcB), .o_regdst(regdstB),
        .o_alu_src(aluSrcB), .o_mem_to_reg(memToRegB), .o_reg_write(regWriteB),
        .o_jal(jalB), .o_alu_op(aluOpB), .o_trap(trapB), .o_trap_cause(causeB),
        .o_retire(retireB), .o_state(stateB)
    );

    assign outA = {busA.mem_ce_n, busA.mem_oe_n, busA.mem_we_n, busA.iord, irwA, pcwA,
                   pcSrcA, regdstA, aluSrcA, memToRegA, regWriteA, jalA, aluOpA,
                   trapA, causeA, retireA, stateA};
    assign outB = {busB.mem_ce_n, busB.mem_oe_n, busB.mem_we_n, busB.iord, irwB, pcwB,
                   pcSrcB, regdstB, aluSrcB, memToRegB, regWriteB, jalB, aluOpB,
                   trapB, causeB, retireB, stateB};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [22:0] v(
        input logic ce, oe, we, iord, irw, pcw, input logic [2:0] pcs,
        input logic rd, as, mtr, rw, jal, input logic [1:0] op,
        input logic tr, input logic [1:0] tc, input logic ret, input logic [2:0] st);
        return {ce, oe, we, iord, irw, pcw, pcs, rd, as, mtr, rw, jal, op, tr, tc, ret, st};
    endfunction

    task automatic applyStimulus(input int sel, input string name, input logic [5:0] opc,
                                 input logic [5:0] fn, input logic zero, input logic rdy,
                                 input logic ack, input logic [22:0] expV);
        exp_t e;
        @(posedge clk);
        #1;
        rstA    = nextRstA;
        rstB    = nextRstB;
        opcode  = opc;
        ins     = fn;
        aluZero = zero;
        ready   = rdy;
        trapAck = ack;
        e.sel   = sel;
        e.v     = expV;
        e.name  = name;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [22:0] act;
        act = (e.sel == 0) ? outA : outB;
        asserts++;
        if (act !== e.v) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.v);
        end
    endtask

    always @(negedge clk) begin
        if (countRetire && retireA === 1'b1) retireCnt++;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        logic [22:0] vIf, vId, vExImm, vIdle0;
        asserts     = 0;
        failures    = 0;
        retireCnt   = 0;
        countRetire = 1'b0;
        opcode = '0; ins = '0; aluZero = 1'b0; ready = 1'b1; trapAck = 1'b0;
        rstA = 1'b1; rstB = 1'b1; nextRstA = 1'b0; nextRstB = 1'b0;
        #2;
        rstA = 1'b0;
        rstB = 1'b0;

        vIf    = v(0,0,1,0,1,1,3'b000,0,0,0,0,0,2'b00,0,2'b00,0,3'd1);
        vId    = v(1,1,1,0,0,0,3'b000,0,0,0,0,0,2'b00,0,2'b00,0,3'd2);
        vExImm = v(1,1,1,0,0,0,3'b000,0,1,0,0,0,2'b00,0,2'b00,0,3'd3);
        vIdle0 = v(1,1,1,0,0,0,3'b000,0,0,0,0,0,2'b00,0,2'b00,0,3'd0);

        $display("[TB] reset and zero-wait instruction stream");
        applyStimulus(0, "reset_held", OP_ADDI, 0, 0, 1, 0, vIdle0);
        nextRstA = 1'b1;
        applyStimulus(0, "rst_cycle", OP_ADDI, 0, 0, 1, 0, vIdle0);

        countRetire = 1'b1;
        applyStimulus(0, "addi_if", OP_ADDI, 0, 0, 1, 0, vIf);
        applyStimulus(0, "addi_id", OP_ADDI, 0, 0, 1, 0, vId);
        applyStimulus(0, "addi_ex", OP_ADDI, 0, 0, 1, 0, vExImm);
        applyStimulus(0, "addi_wb", OP_ADDI, 0, 0, 1, 0, v(1,1,1,0,0,0,3'b000,0,0,0,1,0,2'b00,0,2'b00,1,3'd5));
        applyStimulus(0, "lw_if", OP_LW, 0, 0, 1, 0, vIf);
        applyStimulus(0, "lw_id", OP_LW, 0, 0, 1, 0, vId);
        applyStimulus(0, "lw_ex", OP_LW, 0, 0, 1, 0, vExImm);
        applyStimulus(0, "lw_mem", OP_LW, 0, 0, 1, 0, v(0,0,1,1,0,0,3'b000,0,1,0,0,0,2'b00,0,2'b00,0,3'd4));
        applyStimulus(0, "lw_wb", OP_LW, 0, 0, 1, 0, v(1,1,1,0,0,0,3'b000,0,0,1,1,0,2'b00,0,2'b00,1,3'd5));
        applyStimulus(0, "sw_if", OP_SW, 0, 0, 1, 0, vIf);
        applyStimulus(0, "sw_id", OP_SW, 0, 0, 1, 0, vId);
        applyStimulus(0, "sw_ex", OP_SW, 0, 0, 1, 0, vExImm);
        applyStimulus(0, "sw_mem", OP_SW, 0, 0, 1, 0, v(0,1,0,1,0,0,3'b000,0,1,0,0,0,2'b00,0,2'b00,1,3'd4));
        applyStimulus(0, "beq_if", OP_BEQ, 0, 1, 1, 0, vIf);
        applyStimulus(0, "beq_id", OP_BEQ, 0, 1, 1, 0, vId);
        applyStimulus(0, "beq_ex_taken", OP_BEQ, 0, 1, 1, 0, v(1,1,1,0,0,1,3'b001,0,0,0,0,0,2'b01,0,2'b00,1,3'd3));
        applyStimulus(0, "j_if", OP_J, 0, 0, 1, 0, vIf);
        applyStimulus(0, "j_id", OP_J, 0, 0, 1, 0, v(1,1,1,0,0,1,3'b010,0,0,0,0,0,2'b00,0,2'b00,1,3'd2));
        @(negedge clk);
        #1;
        countRetire = 1'b0;
        asserts++;
        if (retireCnt != 5) begin
            failures++;
            $display("[TB] FAIL retire_count: got %0d expected 5", retireCnt);
        end

        $display("[TB] branches, jumps, R-type");
        applyStimulus(0, "bne_if", OP_BNE, 0, 1, 1, 0, vIf);
        applyStimulus(0, "bne_id", OP_BNE, 0, 1, 1, 0, vId);
        applyStimulus(0, "bne_ex_zero1", OP_BNE, 0, 1, 1, 0, v(1,1,1,0,0,0,3'b001,0,0,0,0,0,2'b01,0,2'b00,1,3'd3));
        applyStimulus(0, "bne2_if", OP_BNE, 0, 0, 1, 0, vIf);
        applyStimulus(0, "bne2_id", OP_BNE, 0, 0, 1, 0, vId);
        applyStimulus(0, "bne_ex_zero0", OP_BNE, 0, 0, 1, 0, v(1,1,1,0,0,1,3'b001,0,0,0,0,0,2'b01,0,2'b00,1,3'd3));
        applyStimulus(0, "jr_if", OP_RTYPE, FN_JR, 0, 1, 0, vIf);
        applyStimulus(0, "jr_id", OP_RTYPE, FN_JR, 0, 1, 0, v(1,1,1,0,0,1,3'b011,0,0,0,0,0,2'b00,0,2'b00,1,3'd2));
        applyStimulus(0, "jal_if", OP_JAL, 0, 0, 1, 0, vIf);
        applyStimulus(0, "jal_id", OP_JAL, 0, 0, 1, 0, v(1,1,1,0,0,1,3'b010,0,0,0,1,1,2'b00,0,2'b00,1,3'd2));
        applyStimulus(0, "add_if", OP_RTYPE, FN_ADD, 0, 1, 0, vIf);
        applyStimulus(0, "add_id", OP_RTYPE, FN_ADD, 0, 1, 0, vId);
        applyStimulus(0, "add_ex", OP_RTYPE, FN_ADD, 0, 1, 0, v(1,1,1,0,0,0,3'b000,0,0,0,0,0,2'b10,0,2'b00,0,3'd3));
        applyStimulus(0, "add_wb", OP_RTYPE, FN_ADD, 0, 1, 0, v(1,1,1,0,0,0,3'b000,1,0,0,1,0,2'b00,0,2'b00,1,3'd5));

        $display("[TB] LW bus timeout");
        applyStimulus(0, "lwto_if", OP_LW, 0, 0, 1, 0, vIf);
        applyStimulus(0, "lwto_id", OP_LW, 0, 0, 1, 0, vId);
        applyStimulus(0, "lwto_ex", OP_LW, 0, 0, 1, 0, vExImm);
        for (int k = 0; k < 15; k++)
            applyStimulus(0, "lwto_wait", OP_LW, 0, 0, 0, 0, v(0,0,1,1,0,0,3'b000,0,1,0,0,0,2'b00,0,2'b00,0,3'd4));
        applyStimulus(0, "lwto_expire", OP_LW, 0, 0, 0, 0, v(1,1,1,1,0,0,3'b000,0,1,0,0,0,2'b00,0,2'b00,0,3'd4));
        applyStimulus(0, "lwto_trap", OP_LW, 0, 0, 1, 0, v(1,1,1,0,0,0,3'b000,0,0,0,0,0,2'b00,1,2'b10,0,3'd6));
        applyStimulus(0, "lwto_ack", OP_LW, 0, 0, 1, 1, v(1,1,1,0,0,1,3'b100,0,0,0,0,0,2'b00,1,2'b10,0,3'd6));
        applyStimulus(0, "after_ack_if_wait", OP_LW, 0, 0, 0, 0, v(0,0,1,0,0,0,3'b000,0,0,0,0,0,2'b00,0,2'b00,0,3'd1));
        applyStimulus(0, "after_ack_if", OP_BAD, 0, 0, 1, 0, vIf);

        $display("[TB] illegal opcode trap");
        applyStimulus(0, "bad_id", OP_BAD, 0, 0, 1, 1, vId);
        applyStimulus(0, "bad_trap", OP_BAD, 0, 0, 1, 0, v(1,1,1,0,0,0,3'b000,0,0,0,0,0,2'b00,1,2'b01,0,3'd6));
        applyStimulus(0, "bad_ack", OP_BAD, 0, 0, 1, 1, v(1,1,1,0,0,1,3'b100,0,0,0,0,0,2'b00,1,2'b01,0,3'd6));
        applyStimulus(0, "bad_after_if", OP_SW, 0, 0, 1, 0, vIf);

        $display("[TB] reset during SW memory access");
        applyStimulus(0, "swr_id", OP_SW, 0, 0, 1, 0, vId);
        applyStimulus(0, "swr_ex", OP_SW, 0, 0, 1, 0, vExImm);
        applyStimulus(0, "swr_mem", OP_SW, 0, 0, 0, 0, v(0,1,0,1,0,0,3'b000,0,1,0,0,0,2'b00,0,2'b00,0,3'd4));
        nextRstA = 1'b0;
        applyStimulus(0, "swr_async_rst", OP_SW, 0, 0, 0, 0, vIdle0);
        nextRstA = 1'b1;
        applyStimulus(0, "swr_rst_cycle", OP_SW, 0, 0, 1, 0, vIdle0);
        applyStimulus(0, "swr_if", OP_SW, 0, 0, 1, 0, vIf);

        $display("[TB] illegal opcode retires with TRAP_EN=0");
        nextRstA = 1'b0;
        nextRstB = 1'b1;
        applyStimulus(1, "nop_rst_cycle", OP_BAD, 0, 0, 1, 0, vIdle0);
        applyStimulus(1, "nop_if", OP_BAD, 0, 0, 1, 0, vIf);
        applyStimulus(1, "nop_id_retire", OP_BAD, 0, 0, 1, 0, v(1,1,1,0,0,0,3'b000,0,0,0,0,0,2'b00,0,2'b00,1,3'd2));
        applyStimulus(1, "nop_next_if", OP_BAD, 0, 0, 0, 0, v(0,0,1,0,0,0,3'b000,0,0,0,0,0,2'b00,0,2'b00,0,3'd1));

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            asserts++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
